oled_fb_scheduler: RTL and testbench

- Single-port scheduler for the OLED frame-buffer memory: 8 rows, each row 12 bytes wide, one 96-bit row per access.
- Shares the memory between a host row-write port and a refresh scanner.
- The scanner reads rows 0..7 in order and streams their bytes over a valid/ready byte interface to the OLED serializer.
- Sits between the host/config logic and the frame-buffer memory; drives its active-low WE_bar/CS_bar strobes directly.

---
 rtl/oled_fb_scheduler.sv | 168 ++++++++++++++++
 tb/tb_oled_fb_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_fb_scheduler.sv
// Purpose: arbitrates one single-port frame-buffer memory (ROWS x BYTES*8) between host
//          row writes and a row-by-row refresh scanner that streams bytes to the serializer.
// Latency: host write slot 1 cycle after grant; first stream byte 3 cycles after scan start.
//          Backpressure: px_ready=0 freezes px_valid/px_data; host writes still proceed during stalls.
// Ports:   clk/rst (sync, active high); wr_req/wr_row/wr_data/wr_ack host write port;
//          refresh_start/busy/frame_done scan control; mem_* memory strobes, address and data;
//          px_valid/px_data/px_last/px_ready byte stream.
module oled_fb_scheduler #(
  parameter int ROWS   = 8,
  parameter int ADDR_W = 3,
  parameter int BYTES  = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_req,
  input  logic [ADDR_W-1:0]       wr_row,
  input  logic [BYTES-1:0][7:0]   wr_data,
  output logic                    wr_ack,
  input  logic                    refresh_start,
  output logic                    busy,
  output logic                    mem_CS_bar,
  output logic                    mem_WE_bar,
  output logic [ADDR_W-1:0]       mem_Address,
  output logic [BYTES-1:0][7:0]   mem_DataIn,
  input  logic [BYTES-1:0][7:0]   mem_DataOut,
  output logic                    px_valid,
  output logic [7:0]              px_data,
  output logic                    px_last,
  input  logic                    px_ready,
  output logic                    frame_done
);

  localparam int IDX_W = $clog2(BYTES);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_CAPTURE, STREAM} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       row_q, row_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    pending_q, pending_d;
  logic [BYTES-1:0][7:0]   rowbuf_q, rowbuf_d;
  logic                    cs_bar_q, cs_bar_d;
  logic                    we_bar_q, we_bar_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [BYTES-1:0][7:0]   din_q, din_d;
  logic                    wr_ack_q, wr_ack_d;
  logic                    frame_done_q, frame_done_d;

  logic hs;
  logic last_hs;
  logic grant;
  logic scan_start;

  assign hs       = (state_q == STREAM) && px_ready;
  assign last_hs  = hs && (idx_q == LAST_IDX);
  // No grant in the ack cycle, and none on the cycle that moves to RD_ISSUE, so the
  // registered write slot can never land on a read strobe.
  assign grant    = wr_req && !wr_ack_q &&
                    ((state_q == IDLE) || ((state_q == STREAM) && !last_hs));
  // Writes win: a scan waits for the first IDLE cycle without a grant.
  assign scan_start = (state_q == IDLE) && !grant && (refresh_start || pending_q);

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    idx_d        = idx_q;
    pending_d    = pending_q;
    rowbuf_d     = rowbuf_q;
    cs_bar_d     = 1'b1;
    we_bar_d     = 1'b1;
    addr_d       = addr_q;
    din_d        = din_q;
    wr_ack_d     = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (scan_start) begin
          row_d   = '0;
          state_d = RD_ISSUE;
        end
      end
      RD_ISSUE: state_d = RD_CAPTURE;
      RD_CAPTURE: begin
        rowbuf_d = mem_DataOut;
        idx_d    = '0;
        state_d  = STREAM;
      end
      STREAM: begin
        if (hs) begin
          if (idx_q == LAST_IDX) begin
            if (row_q == LAST_ROW) begin
              state_d      = IDLE;
              frame_done_d = 1'b1;
            end else begin
              row_d   = row_q + 1'b1;
              state_d = RD_ISSUE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Any number of requests during a frame collapse into one extra frame.
    if (scan_start) begin
      pending_d = 1'b0;
    end else if (refresh_start) begin
      pending_d = 1'b1;
    end

    // Memory strobes are registered: they are asserted in the cycle after the decision.
    if (grant) begin
      cs_bar_d = 1'b0;
      we_bar_d = 1'b0;
      addr_d   = wr_row;
      din_d    = wr_data;
      wr_ack_d = 1'b1;
    end else if (state_d == RD_ISSUE) begin
      cs_bar_d = 1'b0;
      addr_d   = row_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      rowbuf_q     <= '0;
      cs_bar_q     <= 1'b1;
      we_bar_q     <= 1'b1;
      addr_q       <= '0;
      din_q        <= '0;
      wr_ack_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      rowbuf_q     <= rowbuf_d;
      cs_bar_q     <= cs_bar_d;
      we_bar_q     <= we_bar_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      wr_ack_q     <= wr_ack_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign mem_CS_bar  = cs_bar_q;
  assign mem_WE_bar  = we_bar_q;
  assign mem_Address = addr_q;
  assign mem_DataIn  = din_q;
  assign wr_ack      = wr_ack_q;
  assign frame_done  = frame_done_q;
  assign busy        = (state_q != IDLE);
  assign px_valid    = (state_q == STREAM);
  assign px_data     = rowbuf_q[idx_q];
  assign px_last     = (state_q == STREAM) && (row_q == LAST_ROW) && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_oled_fb_scheduler.sv
// Purpose: self-checking bench for oled_fb_scheduler with a behavioural frame-buffer memory.
// Latency: expected stream/timing come from the row/byte ordering rules, not from DUT state.
// Backpressure: px_ready driven constant, toggling or random per scenario.
module tb_oled_fb_scheduler;
  localparam int ROWS   = 8;
  localparam int ADDR_W = 3;
  localparam int BYTES  = 12;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  wr_req;
  logic [ADDR_W-1:0]     wr_row;
  logic [BYTES-1:0][7:0] wr_data;
  logic                  wr_ack;
  logic                  refresh_start;
  logic                  busy;
  logic                  mem_CS_bar;
  logic                  mem_WE_bar;
  logic [ADDR_W-1:0]     mem_Address;
  logic [BYTES-1:0][7:0] mem_DataIn;
  logic [BYTES-1:0][7:0] mem_DataOut;
  logic                  px_valid;
  logic [7:0]            px_data;
  logic                  px_last;
  logic                  px_ready;
  logic                  frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  oled_fb_scheduler #(.ROWS(ROWS), .ADDR_W(ADDR_W), .BYTES(BYTES)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_row(wr_row), .wr_data(wr_data), .wr_ack(wr_ack),
    .refresh_start(refresh_start), .busy(busy),
    .mem_CS_bar(mem_CS_bar), .mem_WE_bar(mem_WE_bar), .mem_Address(mem_Address),
    .mem_DataIn(mem_DataIn), .mem_DataOut(mem_DataOut),
    .px_valid(px_valid), .px_data(px_data), .px_last(px_last), .px_ready(px_ready),
    .frame_done(frame_done)
  );

  // Frame-buffer memory device plus a bench-only backdoor for preloading.
  logic [BYTES-1:0][7:0] mem [ROWS];
  logic                  pl_en;
  logic [ADDR_W-1:0]     pl_row;
  logic [BYTES-1:0][7:0] pl_dat;

  always @(posedge clk) begin
    if (pl_en) mem[pl_row] <= pl_dat;
    else if (!mem_CS_bar) begin
      if (!mem_WE_bar) mem[mem_Address] <= mem_DataIn;
      else             mem_DataOut      <= mem[mem_Address];
    end
  end

  // Reference model: what the frame buffer is intended to hold.
  logic [BYTES-1:0][7:0] model_mem [ROWS];

  // Observations gathered by run_scan.
  logic [7:0] got_q[$];
  int c_first, c_last, c_nlast, c_lasths, c_done, c_busy_done;
  int c_reads, c_rd1, c_stall_bad, c_busy_gap, c_wack, c_wack_valid;

  task automatic preload(input int pattern);
    for (int r = 0; r < ROWS; r++) begin
      for (int i = 0; i < BYTES; i++)
        model_mem[r][i] = (pattern == 0) ? 8'(16 * r + i) : 8'($urandom);
      @(negedge clk);
      pl_en = 1'b1; pl_row = ADDR_W'(r); pl_dat = model_mem[r];
    end
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Drives one frame (optionally started by a refresh pulse) and records what came out.
  // rmode: 0 ready=1, 1 toggling, 2 random. Cycle 0 is the cycle refresh_start is driven.
  task automatic run_scan(input bit do_start, input int rmode, input int wr_at,
                          input logic [ADDR_W-1:0] wrow, input logic [BYTES-1:0][7:0] wdat,
                          input int rs_at);
    logic pv, pr;
    logic [7:0] pd;
    bit done;
    got_q.delete();
    c_first = -1; c_last = -1; c_nlast = 0; c_lasths = -1; c_done = -1; c_busy_done = -1;
    c_reads = 0; c_rd1 = -1; c_stall_bad = 0; c_busy_gap = 0; c_wack = -1; c_wack_valid = 0;
    pv = 1'b0; pr = 1'b0; pd = 8'h00; done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      refresh_start = (do_start && c == 0) || (rs_at >= 0 && (c == rs_at || c == rs_at + 20));
      if (pv && !pr && !(px_valid === 1'b1 && px_data === pd)) c_stall_bad++;
      if (!mem_CS_bar && mem_WE_bar) begin
        c_reads++;
        if (c_rd1 < 0) c_rd1 = c;
      end
      if (c_rd1 >= 0 && !frame_done && !busy) c_busy_gap++;
      if (wr_ack) begin
        c_wack = c; c_wack_valid = px_valid; wr_req = 1'b0;
      end
      if (c == wr_at) begin
        wr_req = 1'b1; wr_row = wrow; wr_data = wdat;
      end
      case (rmode)
        0:       px_ready = 1'b1;
        1:       px_ready = c[0];
        default: px_ready = 1'($urandom_range(0, 1));
      endcase
      if (px_valid && px_ready) begin
        got_q.push_back(px_data);
        if (c_first < 0) c_first = c;
        c_lasths = c;
        if (px_last) begin c_last = c; c_nlast++; end
      end
      if (frame_done) begin c_done = c; c_busy_done = busy; done = 1'b1; end
      pv = px_valid; pr = px_ready; pd = px_data;
    end
    refresh_start = 1'b0;
    wr_req = 1'b0;
  endtask

  function automatic int stream_mismatches();
    int m = 0;
    if (got_q.size() != ROWS * BYTES) m++;
    for (int k = 0; k < got_q.size() && k < ROWS * BYTES; k++)
      if (got_q[k] !== model_mem[k / BYTES][k % BYTES]) m++;
    return m;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (!(mem_CS_bar === 1'b1 && mem_WE_bar === 1'b1 && mem_Address === '0 && mem_DataIn === '0 &&
            wr_ack === 1'b0 && busy === 1'b0 && px_valid === 1'b0 && px_data === 8'h00 &&
            px_last === 1'b0 && frame_done === 1'b0)) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: cs=%b we=%b addr=%0d ack=%b busy=%b pv=%b pd=%h last=%b fd=%b, required idle values",
                 c, mem_CS_bar, mem_WE_bar, mem_Address, wr_ack, busy, px_valid, px_data, px_last, frame_done);
      end
    end
  endtask

  task automatic test_write();
    logic [BYTES-1:0][7:0] d;
    for (int i = 0; i < BYTES; i++) d[i] = 8'(8'h50 + i);
    @(negedge clk);
    wr_req = 1'b1; wr_row = 3'd5; wr_data = d;
    n_checks++;
    if (wr_ack !== 1'b0 || mem_CS_bar !== 1'b1) begin
      n_fail++; $display("FAIL write_T: ack=%b cs=%b, required 0/1", wr_ack, mem_CS_bar);
    end
    @(negedge clk);
    n_checks++;
    if (mem_CS_bar !== 1'b0 || mem_WE_bar !== 1'b0 || mem_Address !== 3'd5 || wr_ack !== 1'b1) begin
      n_fail++; $display("FAIL write_slot: cs=%b we=%b addr=%0d ack=%b, required 0 0 5 1",
                         mem_CS_bar, mem_WE_bar, mem_Address, wr_ack);
    end
    n_checks++;
    if (mem_DataIn !== d) begin
      n_fail++; $display("FAIL write_data: got %h required %h", mem_DataIn, d);
    end
    wr_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_CS_bar !== 1'b1 || mem_WE_bar !== 1'b1 || wr_ack !== 1'b0) begin
      n_fail++; $display("FAIL write_after: cs=%b we=%b ack=%b, required 1 1 0", mem_CS_bar, mem_WE_bar, wr_ack);
    end
    n_checks++;
    if (mem[5] !== d) begin
      n_fail++; $display("FAIL write_mem: row5=%h required %h", mem[5], d);
    end
    model_mem[5] = d;
  endtask

  task automatic test_frame();
    int m;
    preload(0);
    run_scan(1'b1, 0, -1, '0, '0, -1);
    m = stream_mismatches();
    n_checks++;
    if (m !== 0) begin n_fail++; $display("FAIL frame_bytes: %0d mismatches (size %0d), required 0", m, got_q.size()); end
    n_checks++;
    if (c_rd1 !== 1 || c_first !== 3) begin
      n_fail++; $display("FAIL frame_start: read at %0d first byte at %0d, required 1 and 3", c_rd1, c_first);
    end
    n_checks++;
    if (c_last !== 112 || c_nlast !== 1) begin
      n_fail++; $display("FAIL frame_last: px_last at %0d count %0d, required 112 count 1", c_last, c_nlast);
    end
    n_checks++;
    if (c_done !== 113 || c_busy_done !== 0) begin
      n_fail++; $display("FAIL frame_done: at %0d busy=%0d, required 113 busy=0", c_done, c_busy_done);
    end
    n_checks++;
    if (c_reads !== ROWS || c_busy_gap !== 0) begin
      n_fail++; $display("FAIL frame_reads: reads=%0d busy_gaps=%0d, required %0d and 0", c_reads, c_busy_gap, ROWS);
    end
  endtask

  task automatic test_stall(input int rmode, input int pattern);
    int m;
    preload(pattern);
    run_scan(1'b1, rmode, -1, '0, '0, -1);
    m = stream_mismatches();
    n_checks++;
    if (m !== 0) begin n_fail++; $display("FAIL stall%0d_bytes: %0d mismatches, required 0", rmode, m); end
    n_checks++;
    if (c_stall_bad !== 0) begin n_fail++; $display("FAIL stall%0d_stable: %0d unstable stalls, required 0", rmode, c_stall_bad); end
    n_checks++;
    if (c_done < 0 || c_done !== c_lasths + 1 || c_last !== c_lasths) begin
      n_fail++; $display("FAIL stall%0d_done: done %0d last %0d lasths %0d, required done=lasths+1=last+1",
                         rmode, c_done, c_last, c_lasths);
    end
  endtask

  task automatic test_write_during_stream();
    logic [BYTES-1:0][7:0] nd;
    int m;
    preload(1);
    for (int i = 0; i < BYTES; i++) nd[i] = 8'($urandom);
    run_scan(1'b1, 0, 31, 3'd2, nd, -1);
    m = stream_mismatches();
    n_checks++;
    if (m !== 0) begin n_fail++; $display("FAIL wds_old_frame: %0d mismatches, required 0", m); end
    n_checks++;
    if (c_wack !== 32 || c_wack_valid !== 1 || c_reads !== ROWS) begin
      n_fail++; $display("FAIL wds_slot: ack at %0d in_stream=%0d reads=%0d, required 32 1 %0d",
                         c_wack, c_wack_valid, c_reads, ROWS);
    end
    model_mem[2] = nd;
    n_checks++;
    if (mem[2] !== nd) begin n_fail++; $display("FAIL wds_mem: row2=%h required %h", mem[2], nd); end
    run_scan(1'b1, 0, -1, '0, '0, -1);
    m = stream_mismatches();
    n_checks++;
    if (m !== 0) begin n_fail++; $display("FAIL wds_new_frame: %0d mismatches, required 0", m); end
  endtask

  task automatic test_back_to_back();
    logic [BYTES-1:0][7:0] nd;
    int m, bad;
    for (int i = 0; i < BYTES; i++) nd[i] = 8'($urandom);
    run_scan(1'b1, 2, 0, 3'd6, nd, 40);
    model_mem[6] = nd;
    n_checks++;
    if (c_wack !== 1 || c_rd1 !== 2) begin
      n_fail++; $display("FAIL b2b_order: ack at %0d read at %0d, required 1 and 2", c_wack, c_rd1);
    end
    m = stream_mismatches();
    n_checks++;
    if (m !== 0 || c_done !== c_lasths + 1) begin
      n_fail++; $display("FAIL b2b_frame1: %0d mismatches done %0d lasths %0d, required 0 and lasths+1", m, c_done, c_lasths);
    end
    run_scan(1'b0, 0, -1, '0, '0, -1);
    m = stream_mismatches();
    n_checks++;
    if (m !== 0 || c_rd1 !== 0 || c_reads !== ROWS || c_done !== 112) begin
      n_fail++; $display("FAIL b2b_extra: mism %0d read at %0d reads %0d done %0d, required 0 0 %0d 112",
                         m, c_rd1, c_reads, c_done, ROWS);
    end
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy || !mem_CS_bar || px_valid || frame_done) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL b2b_one_extra: %0d active cycles after extra frame, required 0", bad); end
  endtask

  task automatic test_reset_midframe();
    int bad;
    @(negedge clk); refresh_start = 1'b1; px_ready = 1'b1;
    @(negedge clk); refresh_start = 1'b0;
    repeat (30) @(negedge clk);
    refresh_start = 1'b1;
    @(negedge clk); refresh_start = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy: busy=%b, required 1", busy); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (busy || frame_done || !mem_CS_bar || px_valid) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL rst_mid_abort: %0d active cycles after reset, required 0", bad); end
  endtask

  initial begin
    rst = 1'b1; wr_req = 1'b0; wr_row = '0; wr_data = '0; refresh_start = 1'b0;
    px_ready = 1'b0; pl_en = 1'b0; pl_row = '0; pl_dat = '0;
    test_reset();
    test_write();
    test_frame();
    test_stall(1, 0);
    test_stall(2, 1);
    test_write_during_stream();
    test_back_to_back();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
